// File: rtl/alimentador_pkg.sv
// Shared types and constants for the ones-count feeder: FSM state encoding,
// operand/count widths and parameter defaults.
package alimentador_pkg;

  localparam int VAL_W     = 3;
  localparam int CNT_W     = 4;
  localparam int DEPTH_DEF = 4;
  localparam int ACC_W_DEF = 8;

  typedef enum logic [2:0] {
    REPOSO      = 3'd0,
    LANZA       = 3'd1,
    ESPERA_BAJA = 3'd2,
    ESPERA_ALTA = 3'd3,
    SUMA        = 3'd4
  } estado_t;

endpackage

// File: rtl/alimentador_cuenta1_fifo_valores.sv
// fifo_valores: small circular FIFO of operands, with a same-cycle push+pop
// path and a look-ahead port for the word behind the head.
module fifo_valores
  import alimentador_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = VAL_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] dato_in,
  output logic [W-1:0] dato_cab,
  output logic [W-1:0] dato_sig,
  output logic         lleno,
  output logic         vacio,
  output logic         varios
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;
  logic          acepta_s;
  logic          saca_s;

  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign acepta_s = push && (!lleno || pop);
  assign saca_s   = pop && !vacio;

  assign lleno    = (cnt_r == (AW+1)'(DEPTH));
  assign vacio    = (cnt_r == {(AW+1){1'b0}});
  assign varios   = (cnt_r > (AW+1)'(1));
  assign dato_cab = mem_r[rd_ptr_r];
  assign dato_sig = mem_r[rd_ptr_r + AW'(1)];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (acepta_s) begin
      mem_r[wr_ptr_r] <= dato_in;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
    end else begin
      if (acepta_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (saca_s)   rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({acepta_s, saca_s})
        2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/alimentador_cuenta1.sv
// alimentador_cuenta1: feeds queued 3-bit words to an external ones-counter and
// accumulates the returned counts. Define ACUM_SAT_EN for a saturating total.
module alimentador_cuenta1
  import alimentador_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [VAL_W-1:0] dato_in,
  input  logic             push,
  input  logic             borrar,
  output logic             lleno,
  output logic             vacio,
  output logic [VAL_W-1:0] valor,
  output logic             start,
  input  logic [CNT_W-1:0] cuenta,
  input  logic             fin,
  output logic [ACC_W-1:0] total,
  output logic             ocupado
);

  estado_t            estado_r, estado_s;
  logic [VAL_W-1:0]   valor_r, valor_s;
  logic [VAL_W-1:0]   cab_s, sig_s;
  logic [CNT_W-1:0]   cuenta_r;
  logic [ACC_W-1:0]   total_r, total_s, acum_s, cuenta_ext_s;
  logic               start_r, ocupado_r;
  logic               pop_s, varios_s;

  fifo_valores #(.DEPTH(DEPTH), .W(VAL_W)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop_s),
    .dato_in  (dato_in),
    .dato_cab (cab_s),
    .dato_sig (sig_s),
    .lleno    (lleno),
    .vacio    (vacio),
    .varios   (varios_s)
  );

  assign pop_s        = (estado_r == SUMA);
  assign cuenta_ext_s = ACC_W'(cuenta_r);

`ifdef ACUM_SAT_EN
  logic [ACC_W:0] suma_s;
  assign suma_s = {1'b0, total_r} + {1'b0, cuenta_ext_s};
  assign acum_s = suma_s[ACC_W] ? {ACC_W{1'b1}} : suma_s[ACC_W-1:0];
`else
  assign acum_s = total_r + cuenta_ext_s;
`endif

  // Next-state and operand selection; valor only changes when entering LANZA.
  always_comb begin
    estado_s = estado_r;
    valor_s  = valor_r;
    case (estado_r)
      REPOSO: begin
        if (!vacio) begin
          estado_s = LANZA;
          valor_s  = cab_s;
        end else begin
          estado_s = REPOSO;
        end
      end
      LANZA:       estado_s = ESPERA_BAJA;
      ESPERA_BAJA: estado_s = fin ? ESPERA_BAJA : ESPERA_ALTA;
      ESPERA_ALTA: estado_s = fin ? SUMA : ESPERA_ALTA;
      SUMA: begin
        // After the pop the next head is either the queued follower or the
        // word being pushed right now into a one-entry FIFO.
        if (varios_s) begin
          estado_s = LANZA;
          valor_s  = sig_s;
        end else if (push) begin
          estado_s = LANZA;
          valor_s  = dato_in;
        end else begin
          estado_s = REPOSO;
        end
      end
      default: estado_s = REPOSO;
    endcase
  end

  // Accumulator update: a clear coinciding with an add keeps just that count.
  always_comb begin
    total_s = total_r;
    if (pop_s && borrar) begin
      total_s = cuenta_ext_s;
    end else if (pop_s) begin
      total_s = acum_s;
    end else if (borrar) begin
      total_s = {ACC_W{1'b0}};
    end else begin
      total_s = total_r;
    end
  end

  // State, operand, accumulator and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_r  <= REPOSO;
      valor_r   <= {VAL_W{1'b0}};
      cuenta_r  <= {CNT_W{1'b0}};
      total_r   <= {ACC_W{1'b0}};
      start_r   <= 1'b0;
      ocupado_r <= 1'b0;
    end else begin
      estado_r  <= estado_s;
      valor_r   <= valor_s;
      total_r   <= total_s;
      start_r   <= (estado_s == LANZA);
      ocupado_r <= (estado_s != REPOSO);
      if ((estado_r == ESPERA_ALTA) && fin) begin
        cuenta_r <= cuenta;
      end
    end
  end

  assign valor   = valor_r;
  assign start   = start_r;
  assign total   = total_r;
  assign ocupado = ocupado_r;

endmodule

// File: tb/tb_alimentador_cuenta1.sv
// Self-checking bench for alimentador_cuenta1 with a behavioural ones-counter
// and a scoreboard of operands expected at each start pulse.
module tb_alimentador_cuenta1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       push = 1'b0;
  logic       borrar = 1'b0;
  logic [2:0] dato_in = 3'd0;
  logic [3:0] cuenta;
  logic       fin;
  logic       lleno, vacio, start, ocupado;
  logic [2:0] valor;
  logic [7:0] total;

  alimentador_cuenta1 #(.DEPTH(4), .ACC_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .dato_in(dato_in), .push(push),
    .borrar(borrar), .lleno(lleno), .vacio(vacio), .valor(valor),
    .start(start), .cuenta(cuenta), .fin(fin), .total(total),
    .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  // Counter model controls
  int         lat = 3;
  int         hold_dly = 0;
  logic       stall = 1'b0;
  logic       ovr_en = 1'b0;
  logic [3:0] ovr_val = 4'd0;
  int         busy, hold;
  logic [2:0] cap;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fin <= 1'b0; cuenta <= 4'd0; busy <= 0; hold <= 0; cap <= 3'd0;
    end else if (start) begin
      cap  <= valor;
      busy <= lat;
      hold <= hold_dly;
      if (hold_dly == 0) fin <= 1'b0;
    end else if (hold > 0) begin
      hold <= hold - 1;
      if (hold == 1) fin <= 1'b0;
    end else if (busy > 0 && !stall) begin
      busy <= busy - 1;
      if (busy == 1) begin
        fin    <= 1'b1;
        cuenta <= ovr_en ? ovr_val : 4'($countones(cap));
      end
    end
  end

  int         total_n = 0;
  int         bad_n = 0;
  int         n_starts = 0;
  logic [2:0] exp_q[$];
  logic [2:0] burst[$];
  logic [2:0] cur_valor = 3'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: each start must present the next queued word, held until done.
  always @(negedge clk) begin
    if (reset_n) begin
      if (start) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          total_n++; bad_n++;
          $display("FAIL start_extra: got valor=%0d expected no start", valor);
        end else begin
          cur_valor = exp_q.pop_front();
          chk("valor_at_start", valor, cur_valor);
        end
      end else if (ocupado) begin
        chk("valor_stable", valor, cur_valor);
      end
    end
  end

  task automatic push_burst(input int n_acc);
    for (int i = 0; i < burst.size(); i++) begin
      @(negedge clk);
      dato_in = burst[i];
      push = 1'b1;
      if (i < n_acc) exp_q.push_back(burst[i]);
    end
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic push_word(input logic [2:0] d);
    burst = {d};
    push_burst(1);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while ((ocupado || !vacio) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      total_n++; bad_n++;
      $display("FAIL idle_timeout: got ocupado=%0d expected 0", ocupado);
    end
  endtask

  task automatic wait_fin(input logic lvl);
    int k = 0;
    while (fin !== lvl && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      total_n++; bad_n++;
      $display("FAIL fin_timeout: got fin=%0d expected %0d", fin, lvl);
    end
  endtask

  task automatic clear_total();
    @(negedge clk); borrar = 1'b1;
    @(negedge clk); borrar = 1'b0;
    chk("borrar_alone", total, 0);
  endtask

  typedef struct {
    logic [2:0] dato;
    logic [7:0] total;
  } vec_t;
  vec_t tabla[6];

  initial begin
    int s0;
    tabla[0] = '{3'b111, 8'd3};
    tabla[1] = '{3'b101, 8'd5};
    tabla[2] = '{3'b000, 8'd5};
    tabla[3] = '{3'b010, 8'd6};
    tabla[4] = '{3'b110, 8'd8};
    tabla[5] = '{3'b001, 8'd9};

    // Reset values
    #1;
    chk("rst_vacio", vacio, 1);   chk("rst_lleno", lleno, 0);
    chk("rst_total", total, 0);   chk("rst_valor", valor, 0);
    chk("rst_start", start, 0);   chk("rst_ocupado", ocupado, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single-word transactions
    for (int i = 0; i < 6; i++) begin
      s0 = n_starts;
      push_word(tabla[i].dato);
      wait_idle();
      chk("tab_total", total, tabla[i].total);
      chk("tab_starts", n_starts - s0, 1);
      chk("tab_vacio", vacio, 1);
    end

    // Back-to-back pushes
    clear_total();
    s0 = n_starts;
    burst = {3'b111, 3'b101, 3'b000};
    push_burst(3);
    wait_idle();
    chk("b2b_total", total, 5);
    chk("b2b_starts", n_starts - s0, 3);

    // Stalled counter: FIFO fills, fifth word dropped
    clear_total();
    stall = 1'b1;
    s0 = n_starts;
    burst = {3'b011, 3'b110, 3'b001, 3'b111, 3'b100};
    push_burst(4);
    chk("full_lleno", lleno, 1);
    chk("full_ocupado", ocupado, 1);
    repeat (5) @(negedge clk);
    stall = 1'b0;
    wait_idle();
    chk("full_total", total, 8);
    chk("full_starts", n_starts - s0, 4);

    // Stale fin held after each start
    clear_total();
    hold_dly = 3;
    burst = {3'b110, 3'b011};
    push_burst(2);
    wait_idle();
    chk("stale_total", total, 4);
    hold_dly = 0;

    // Reset while waiting on the counter
    stall = 1'b1;
    push_word(3'b111);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_ocupado", ocupado, 0); chk("midrst_vacio", vacio, 1);
    chk("midrst_total", total, 0);     chk("midrst_valor", valor, 0);
    chk("midrst_start", start, 0);     chk("midrst_lleno", lleno, 0);
    stall = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    push_word(3'b111);
    wait_idle();
    chk("post_rst_total", total, 3);

    // Clear coinciding with an add of cuenta=2
    ovr_en = 1'b1; ovr_val = 4'd2;
    push_word(3'b011);
    wait_fin(1'b0);
    wait_fin(1'b1);
    @(negedge clk); borrar = 1'b1;
    @(negedge clk); borrar = 1'b0;
    wait_idle();
    chk("borrar_suma_total", total, 2);

    // Overflow with counts above 3
    clear_total();
    ovr_val = 4'd15;
    for (int i = 0; i < 17; i++) begin
      push_word(3'b001);
      wait_idle();
    end
    chk("acc_255", total, 255);
    push_word(3'b001);
    wait_idle();
`ifdef ACUM_SAT_EN
    chk("acc_sat", total, 255);
`else
    chk("acc_wrap", total, 14);
`endif
    clear_total();
    ovr_en = 1'b0;

    // Push into a full FIFO in the cycle it pops
    stall = 1'b1;
    s0 = n_starts;
    burst = {3'b100, 3'b010, 3'b001, 3'b110};
    push_burst(4);
    chk("pf_lleno", lleno, 1);
    stall = 1'b0;
    wait_fin(1'b1);
    @(negedge clk);
    dato_in = 3'b111; push = 1'b1; exp_q.push_back(3'b111);
    @(negedge clk);
    push = 1'b0;
    wait_idle();
    chk("pf_total", total, 8);
    chk("pf_starts", n_starts - s0, 5);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/alimentador_cuenta1.md
ALIMENTADOR_CUENTA1 -- requirements
Module: alimentador_cuenta1

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in 3-bit words (power of two, 2..16), SHALL be supported.
REQ-002 Parameter ACC_W, default 8, width of the running total, SHALL be supported.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 dato_in  input  3  value to enqueue.
REQ-006 push  input  1  enqueue strobe, one word per cycle.
REQ-007 borrar  input  1  synchronous clear of total.
REQ-008 lleno  output  1  FIFO full.
REQ-009 vacio  output  1  FIFO empty.
REQ-010 valor  output  3  operand driven to the ones-counter.
REQ-011 start  output  1  one-cycle launch pulse to the ones-counter.
REQ-012 cuenta  input  4  ones count returned by the counter.
REQ-013 fin  input  1  counter done flag.
REQ-014 total  output  ACC_W  accumulated ones count.
REQ-015 ocupado  output  1  high whenever the FSM is not in REPOSO.

Function
REQ-016 The FSM SHALL have states REPOSO, LANZA, ESPERA_BAJA, ESPERA_ALTA and SUMA.
REQ-017 REPOSO->LANZA when vacio=0; valor SHALL be loaded from the FIFO head on this transition.
REQ-018 In LANZA, start=1 for exactly one cycle; next state is ESPERA_BAJA.
REQ-019 ESPERA_BAJA->ESPERA_ALTA when fin=0 (discards a stale fin from the previous operation).
REQ-020 ESPERA_ALTA->SUMA when fin=1; cuenta SHALL be sampled on that edge.
REQ-021 In SUMA: total += sampled cuenta (zero-extended), FIFO head popped; next state LANZA if another word remains after the pop, else REPOSO.
REQ-022 valor SHALL stay stable from LANZA through SUMA.
REQ-023 Minimum latency from push into an empty idle block to total update SHALL be 4 cycles plus the counter's busy time.
REQ-024 push while lleno=1 SHALL be dropped, unless the same cycle pops (SUMA), in which case it SHALL be accepted.
REQ-025 Default overflow behaviour: total wraps modulo 2^ACC_W.
REQ-026 borrar in the same cycle as SUMA: total SHALL become the sampled cuenta; borrar alone: total SHALL become 0.
REQ-027 cuenta values above 3 SHALL still be added as received.

Reset
REQ-028 reset_n=0 SHALL immediately force REPOSO, FIFO empty (vacio=1, lleno=0), total=0, valor=0, start=0, ocupado=0.
REQ-029 Reset during any state SHALL discard the in-flight operation; no partial add.
REQ-030 After release, the first word SHALL be accepted on the first rising edge with push=1.

Configuration
REQ-031 Macro ACUM_SAT_EN defined: total SHALL saturate at 2^ACC_W-1 and hold until borrar or reset.
REQ-032 Macro ACUM_SAT_EN undefined: wrap per REQ-025; no saturation logic synthesised.

Structure
REQ-033 Shared package alimentador_pkg SHALL hold the state encoding type, the 3-bit value width constant, the 4-bit count width constant and DEPTH/ACC_W defaults.
REQ-034 The FIFO SHALL be a sub-module fifo_valores (push/pop, lleno/vacio, same-cycle push+pop); the FSM and accumulator live in the top.

Verification
REQ-035 Reset, push 3'b111, counter model returns cuenta=3 after 3 busy cycles -> one start pulse, valor=111 throughout, total=3, vacio=1, ocupado=0.
REQ-036 Push 111,101,000 back-to-back -> three start pulses in order, valor sequence 111,101,000, final total=5.
REQ-037 Stall counter, push 5 words with DEPTH=4 -> lleno=1 after 4, fifth dropped, exactly 4 starts after release, total=sum of 4.
REQ-038 Model holding fin=1 from a prior operation -> no SUMA until fin drops then rises; total adds once per word.
REQ-039 ACC_W=4, feed six words of 111 -> without ACUM_SAT_EN total=2 (18 mod 16); with it total=15.
REQ-040 Assert reset_n=0 in ESPERA_ALTA, then borrar concurrent with a SUMA of cuenta=2 -> outputs per REQ-028 immediately, then total=2.
